// File: rtl/baud_generator_os.sv
// -----------------------------------------------------------------------------
// baud_generator_os
//
// UART baud tick generator with an oversample tick and a derived bit tick.
// Divisors for the eight supported rates are computed at elaboration from
// CLK_HZ and OVERSAMPLE. Rate changes take effect only on a period boundary,
// so neither engine ever sees a short or stretched period. The RX engine can
// realign the bit phase to the centre of a start bit with a resync pulse.
//
// Optional feature macro: FRACTIONAL_DIV_EN
//   Defined     : truncated integer divisor plus a FRAC_W-bit fractional
//                 accumulator; a carry out of the accumulator stretches the
//                 following sample period by one clock.
//   Not defined : rounded integer divisor only; no accumulator is built.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   OVERSAMPLE  sample ticks per bit (even, 4..64)
//   DIV_W       divisor counter width
//   FRAC_W      fractional accumulator width (fractional build only)
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   1 = running; 0 = counters held at 0, no ticks
//   baud_select    in   requested rate 0..7 = 300..115200 baud
//   resync         in   1-cycle pulse on RX start-bit edge
//   sample_ENABLE  out  1-cycle oversample tick
//   bit_tick       out  1-cycle bit tick, coincident with a sample tick
//   active_sel     out  rate currently in effect
//   rate_changed   out  1-cycle pulse when a new rate takes effect
// -----------------------------------------------------------------------------
module baud_generator_os #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] baud_select,
  input  logic       resync,
  output logic       sample_ENABLE,
  output logic       bit_tick,
  output logic [2:0] active_sel,
  output logic       rate_changed
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  function automatic longint baud_rate(input int idx);
    case (idx)
      0:       return 64'd300;
      1:       return 64'd1200;
      2:       return 64'd4800;
      3:       return 64'd9600;
      4:       return 64'd19200;
      5:       return 64'd38400;
      6:       return 64'd57600;
      default: return 64'd115200;
    endcase
  endfunction

  // Fractional part of CLK_HZ/(baud*OVERSAMPLE), rounded to FRAC_W bits.
  // A fraction that rounds up to a whole cycle is folded into the integer part.
  function automatic longint frac_part(input int idx);
    longint den;
    longint f;
    den = baud_rate(idx) * longint'(OVERSAMPLE);
    f   = (((longint'(CLK_HZ) % den) << FRAC_W) * 2 + den) / (2 * den);
    if (f == (longint'(1) << FRAC_W)) f = 0;
    return f;
  endfunction

  function automatic longint int_div(input int idx);
    longint den;
    longint q;
    den = baud_rate(idx) * longint'(OVERSAMPLE);
`ifdef FRACTIONAL_DIV_EN
    q = longint'(CLK_HZ) / den;
    if ((((longint'(CLK_HZ) % den) << FRAC_W) * 2 + den) / (2 * den) == (longint'(1) << FRAC_W))
      q = q + 1;
`else
    q = (2 * longint'(CLK_HZ) + den) / (2 * den);
`endif
    return q;
  endfunction

  function automatic logic [8*DIV_W-1:0] build_div_tab();
    logic [8*DIV_W-1:0] tab;
    tab = '0;
    for (int i = 0; i < 8; i++) tab[i*DIV_W +: DIV_W] = DIV_W'(int_div(i));
    return tab;
  endfunction

  localparam logic [8*DIV_W-1:0] DIV_TAB = build_div_tab();

  // Elaboration-time sanity checks on every divisor and on the parameters.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div_check
      if (int_div(gi) < 2 || int_div(gi) >= (longint'(1) << DIV_W)) begin : g_bad_div
        $error("baud_generator_os: divisor out of range for DIV_W");
      end
`ifdef FRACTIONAL_DIV_EN
      // A stretched period counts to D, which must still fit the counter.
      if (int_div(gi) + 1 >= (longint'(1) << DIV_W)) begin : g_bad_frac_div
        $error("baud_generator_os: stretched divisor out of range for DIV_W");
      end
`endif
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("baud_generator_os: OVERSAMPLE must be even and within 4..64");
    end
    if (FRAC_W < 1 || FRAC_W > 16) begin : g_bad_frac_w
      $error("baud_generator_os: FRAC_W must be within 1..16");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [OS_W-1:0]  os_cnt_reg, os_cnt_next;
  logic [2:0]       active_sel_reg, active_sel_next;
  logic             sample_reg, sample_next;
  logic             bit_reg, bit_next;
  logic             rc_reg, rc_next;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] div_last;
  logic             sel_mismatch;

`ifdef FRACTIONAL_DIV_EN
  function automatic logic [8*FRAC_W-1:0] build_frac_tab();
    logic [8*FRAC_W-1:0] tab;
    tab = '0;
    for (int i = 0; i < 8; i++) tab[i*FRAC_W +: FRAC_W] = FRAC_W'(frac_part(i));
    return tab;
  endfunction

  localparam logic [8*FRAC_W-1:0] FRAC_TAB = build_frac_tab();

  logic [FRAC_W-1:0] frac_acc_reg, frac_acc_next;
  logic              extra_reg, extra_next;  // current period is one cycle longer
  logic [FRAC_W-1:0] cur_frac;
  logic [FRAC_W:0]   frac_sum;

  always_comb begin
    cur_frac = FRAC_TAB[int'(active_sel_reg)*FRAC_W +: FRAC_W];
    frac_sum = {1'b0, frac_acc_reg} + {1'b0, cur_frac};
  end
`endif

  always_comb begin
    cur_div = DIV_TAB[int'(active_sel_reg)*DIV_W +: DIV_W];
`ifdef FRACTIONAL_DIV_EN
    div_last = cur_div - DIV_W'(1) + DIV_W'(extra_reg);
`else
    div_last = cur_div - DIV_W'(1);
`endif
    sel_mismatch = (baud_select != active_sel_reg);
  end

  always_comb begin
    div_cnt_next    = div_cnt_reg;
    os_cnt_next     = os_cnt_reg;
    active_sel_next = active_sel_reg;
    sample_next     = 1'b0;
    bit_next        = 1'b0;
    rc_next         = 1'b0;
`ifdef FRACTIONAL_DIV_EN
    frac_acc_next   = frac_acc_reg;
    extra_next      = extra_reg;
`endif

    if (!enable) begin
      // Idle: counters parked, a new rate is adopted immediately.
      div_cnt_next = '0;
      os_cnt_next  = '0;
`ifdef FRACTIONAL_DIV_EN
      frac_acc_next = '0;
      extra_next    = 1'b0;
`endif
      if (sel_mismatch) begin
        active_sel_next = baud_select;
        rc_next         = 1'b1;
      end
    end else if (resync) begin
      // Start the bit half-way so the next bit_tick lands mid start bit.
      // Any tick or pending rate change in this cycle is dropped.
      div_cnt_next = '0;
      os_cnt_next  = OS_HALF;
`ifdef FRACTIONAL_DIV_EN
      frac_acc_next = '0;
      extra_next    = 1'b0;
`endif
    end else if (div_cnt_reg == div_last) begin
      div_cnt_next = '0;
      sample_next  = 1'b1;
      if (os_cnt_reg == OS_LAST) begin
        os_cnt_next = '0;
        bit_next    = 1'b1;
      end else begin
        os_cnt_next = os_cnt_reg + OS_W'(1);
      end
      // Rate changes only at a period boundary: the next period is a full
      // period of the new divisor.
      if (sel_mismatch) begin
        active_sel_next = baud_select;
        rc_next         = 1'b1;
`ifdef FRACTIONAL_DIV_EN
        frac_acc_next = '0;
        extra_next    = 1'b0;
`endif
      end else begin
`ifdef FRACTIONAL_DIV_EN
        frac_acc_next = frac_sum[FRAC_W-1:0];
        extra_next    = frac_sum[FRAC_W];
`endif
      end
    end else begin
      div_cnt_next = div_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg    <= '0;
      os_cnt_reg     <= '0;
      active_sel_reg <= 3'd0;
      sample_reg     <= 1'b0;
      bit_reg        <= 1'b0;
      rc_reg         <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      os_cnt_reg     <= os_cnt_next;
      active_sel_reg <= active_sel_next;
      sample_reg     <= sample_next;
      bit_reg        <= bit_next;
      rc_reg         <= rc_next;
    end
  end

`ifdef FRACTIONAL_DIV_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frac_acc_reg <= '0;
      extra_reg    <= 1'b0;
    end else begin
      frac_acc_reg <= frac_acc_next;
      extra_reg    <= extra_next;
    end
  end
`endif

  assign sample_ENABLE = sample_reg;
  assign bit_tick      = bit_reg;
  assign active_sel    = active_sel_reg;
  assign rate_changed  = rc_reg;

endmodule

// File: tb/tb_baud_generator_os.sv
// -----------------------------------------------------------------------------
// tb_baud_generator_os
//
// Directed sequence with randomized change/resync points. Expected tick
// periods come from the divisor arithmetic (rounded or floor+fraction) and
// expected bit ticks from counting sample ticks since the last alignment
// point (enable rising or resync).
// -----------------------------------------------------------------------------
module tb_baud_generator_os;

  localparam longint CLK_HZ = 50_000_000;
  localparam int     OS     = 16;
  localparam int     FW     = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [2:0] baud_select;
  logic       resync;
  logic       sample_ENABLE;
  logic       bit_tick;
  logic [2:0] active_sel;
  logic       rate_changed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  baud_generator_os #(
    .CLK_HZ(50_000_000), .OVERSAMPLE(OS), .DIV_W(16), .FRAC_W(FW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .baud_select(baud_select),
    .resync(resync), .sample_ENABLE(sample_ENABLE), .bit_tick(bit_tick),
    .active_sel(active_sel), .rate_changed(rate_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint baud_of(input int sel);
    case (sel)
      0: return 300;     1: return 1200;   2: return 4800;  3: return 9600;
      4: return 19200;   5: return 38400;  6: return 57600; default: return 115200;
    endcase
  endfunction

  // Length of the j-th sample period after the fractional state was cleared.
  function automatic longint exp_period(input int sel, input longint j);
    longint den;
    longint di;
    longint f;
    den = baud_of(sel) * OS;
`ifdef FRACTIONAL_DIV_EN
    di = CLK_HZ / den;
    f  = ((CLK_HZ % den) * (longint'(1) << FW) * 2 + den) / (2 * den);
    if (f == (longint'(1) << FW)) begin
      di = di + 1;
      f  = 0;
    end
    if (j == 0) return di;
    return di + (j * f) / (longint'(1) << FW) - ((j - 1) * f) / (longint'(1) << FW);
`else
    di = (2 * CLK_HZ + den) / (2 * den);
    f  = j;
    return di + (f - j);
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for the next sample tick; returns the cycle count at which it is seen.
  task automatic next_tick(input int budget, output int t);
    int n;
    n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (sample_ENABLE !== 1'b1 && n < budget);
    if (sample_ENABLE === 1'b1) t = cyc;
    else check("tick_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int t, t_prev, c0, cur, nxt, mid, r, n, off, cnt;
    longint j, p, span, exp_span, rs_acc;

    reset_n = 1'b0; enable = 1'b0; baud_select = 3'd0; resync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sample", sample_ENABLE, 0);
    check("rst_bit", bit_tick, 0);
    check("rst_active", active_sel, 0);
    check("rst_rc", rate_changed, 0);

    // Rate selection while idle applies on the next cycle.
    reset_n = 1'b1; baud_select = 3'd7;
    @(negedge clk);
    check("idle_sel_applied", active_sel, 7);
    check("idle_rc", rate_changed, 1);
    @(negedge clk);
    check("idle_rc_pulse", rate_changed, 0);

    // Enable: first tick after one full period.
    cur = 7; c0 = cyc; enable = 1'b1;
    next_tick(20000, t);
    check("en_latency", t - c0, exp_period(cur, 0));
    j = 1; n = 1; off = 0;
    check("en_first_bit", bit_tick, ((n + off) % OS) == 0);

    // 256 steady periods at 115200.
    span = 0; exp_span = 0;
    for (int k = 0; k < 256; k++) begin
      t_prev = t;
      next_tick(20000, t);
      n++;
      check("period_s7", t - t_prev, exp_period(cur, j));
      check("bit_s7", bit_tick, ((n + off) % OS) == 0);
      span += t - t_prev;
      exp_span += exp_period(cur, j);
      j++;
    end
    check("span_256", span, exp_span);
`ifdef FRACTIONAL_DIV_EN
    check("span_256_abs", span, 6944);
`else
    check("span_256_abs", span, 6912);
`endif

    // Random mid-period rate changes; an intermediate value is overwritten.
    repeat (4) begin
      do nxt = int'($urandom_range(3, 7)); while (nxt == cur);
      mid = int'($urandom_range(3, 7));
      p = exp_period(cur, j);
      r = int'($urandom_range(1, 32'(p - 3)));
      repeat (r) @(negedge clk);
      baud_select = 3'(mid);
      @(negedge clk);
      baud_select = 3'(nxt);
      t_prev = t;
      next_tick(20000, t);
      n++;
      check("chg_old_period", t - t_prev, p);
      check("chg_rc", rate_changed, 1);
      check("chg_active", active_sel, nxt);
      check("chg_bit", bit_tick, ((n + off) % OS) == 0);
      cur = nxt; j = 0;
      t_prev = t;
      next_tick(20000, t);
      n++;
      check("chg_new_period", t - t_prev, exp_period(cur, j));
      check("chg_rc_clear", rate_changed, 0);
      check("chg_bit2", bit_tick, ((n + off) % OS) == 0);
      j = 1;
    end

    // Return to 115200 for the resync tests.
    if (cur != 7) begin
      baud_select = 3'd7;
      t_prev = t;
      next_tick(20000, t);
      n++;
      check("to7_period", t - t_prev, exp_period(cur, j));
      check("to7_rc", rate_changed, 1);
      cur = 7; j = 0;
    end

    // Resync mid-period: bit phase realigns to the start-bit centre.
    p = exp_period(cur, j);
    r = int'($urandom_range(2, 32'(p - 3)));
    repeat (r) @(negedge clk);
    resync = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    resync = 1'b0;
    next_tick(20000, t);
    check("rs_first_sample", t - c0, exp_period(cur, 0));
    j = 1; n = 1; off = OS / 2; rs_acc = exp_period(cur, 0);
    check("rs_bit_first", bit_tick, ((n + off) % OS) == 0);
    for (int k = 0; k < 24; k++) begin
      t_prev = t;
      next_tick(20000, t);
      n++;
      check("rs_period", t - t_prev, exp_period(cur, j));
      check("rs_bit", bit_tick, ((n + off) % OS) == 0);
      rs_acc += exp_period(cur, j);
      if (n == OS / 2) check("rs_bit_time", t - c0, rs_acc);
      j++;
    end

    // Resync coinciding with a tick and with a pending rate change.
    p = exp_period(cur, j);
    repeat (32'(p - 1)) @(negedge clk);
    baud_select = 3'd3;
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    c0 = cyc;
    check("rs_tick_suppressed", sample_ENABLE, 0);
    check("rs_no_change", active_sel, cur);
    check("rs_no_rc", rate_changed, 0);
    next_tick(20000, t);
    check("rs2_period", t - c0, exp_period(cur, 0));
    check("rs2_rc", rate_changed, 1);
    check("rs2_active", active_sel, 3);
    n = 1; off = OS / 2;
    check("rs2_bit", bit_tick, ((n + off) % OS) == 0);
    cur = 3; j = 0;
    t_prev = t;
    next_tick(20000, t);
    n++;
    check("s3_period", t - t_prev, exp_period(cur, j));
`ifndef FRACTIONAL_DIV_EN
    check("s3_period_abs", t - t_prev, 326);
`endif
    j = 1;

    // Disable: no ticks; a new rate is taken while idle.
    repeat (5) @(negedge clk);
    enable = 1'b0; baud_select = 3'd7; cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sample_ENABLE === 1'b1 || bit_tick === 1'b1) cnt++;
    end
    check("dis_no_ticks", cnt, 0);
    check("dis_active", active_sel, 7);

    // Re-enable: full period latency, bit phase restarts.
    cur = 7; c0 = cyc; enable = 1'b1;
    next_tick(20000, t);
    check("reen_latency", t - c0, exp_period(cur, 0));
    j = 1; n = 1; off = 0;
    for (int k = 0; k < 16; k++) begin
      t_prev = t;
      next_tick(20000, t);
      n++;
      check("reen_period", t - t_prev, exp_period(cur, j));
      check("reen_bit", bit_tick, ((n + off) % OS) == 0);
      j++;
    end

    // Asynchronous reset between clock edges.
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_active", active_sel, 0);
    check("arst_sample", sample_ENABLE, 0);
    check("arst_bit", bit_tick, 0);
    check("arst_rc", rate_changed, 0);
    enable = 1'b0; baud_select = 3'd0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sample_ENABLE === 1'b1 || bit_tick === 1'b1) cnt++;
    end
    check("arst_idle_no_ticks", cnt, 0);
    check("arst_idle_active", active_sel, 0);

    // Slowest rate: largest divisor fits the counter.
    cur = 0; c0 = cyc; enable = 1'b1;
    next_tick(12000, t);
    check("s0_latency", t - c0, exp_period(cur, 0));
    j = 1;
    repeat (2) begin
      t_prev = t;
      next_tick(12000, t);
      check("s0_period", t - t_prev, exp_period(cur, j));
`ifndef FRACTIONAL_DIV_EN
      check("s0_period_abs", t - t_prev, 10417);
`endif
      j++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
